// File: rtl/ram2_port_arbiter_pkg.sv
// Shared types and constants for the RAM port-2 arbiter.
// The optional RAM_ARB_PERF_EN build also uses PERF_CNT_W from here.
package ram_arb_pkg;

    // Width of the host starvation counter (saturates at 15)
    localparam int WAIT_CNT_W = 4;

    // Width of the optional stall counters
    localparam int PERF_CNT_W = 16;

    // Arbiter state: which requester, if any, is issuing this cycle
    typedef enum logic [1:0] {
        IDLE,
        ISSUE_CPU,
        ISSUE_HOST
    } arb_state_t;

    // Identity of the requester chosen at a decision edge
    typedef enum logic {
        REQ_CPU,
        REQ_HOST
    } requester_e;

endpackage

// File: rtl/ram2_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and RAM port 2.
// The arbiter connects through the slave modport. The master modport
// is for whatever drives the requests and models the RAM.
interface ram2_port_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    import ram_arb_pkg::*;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;

    logic [DW-1:0] rdata;

    logic          ram_w_en2;
    logic [AW-1:0] ram_addr2;
    logic [DW-1:0] ram_in2;
    logic [DW-1:0] ram_data2;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  ram_data2,
        output cpu_gnt, cpu_rvalid, host_gnt, host_rvalid,
        output rdata, ram_w_en2, ram_addr2, ram_in2
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output ram_data2,
        input  cpu_gnt, cpu_rvalid, host_gnt, host_rvalid,
        input  rdata, ram_w_en2, ram_addr2, ram_in2
    );

endinterface

// File: rtl/ram2_port_arbiter_starve_cnt.sv
// Saturating up-counter with increment, clear and a ">= limit" flag.
// Used as the host starvation counter and, at 16 bits, as a stall counter.
module arb_starve_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    // Count up on inc, stick at all-ones, clear takes priority over inc
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_limit = (count >= limit);

endmodule

// File: rtl/ram2_port_arbiter.sv
// RAM port-2 arbiter: CPU load/store path versus host loader/debug port.
// Fixed CPU priority. The host overrides it once it has lost STARVE_LIMIT
// decisions (legal range 1..15). Each grant issues one registered RAM
// command. Read data comes back through rdata one cycle later.
// Define RAM_ARB_PERF_EN to add the cpu_stall_cnt/host_stall_cnt outputs.
module ram2_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW           = 11,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ram2_port_arbiter_if.slave     bus
`ifdef RAM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]  cpu_stall_cnt,
    output logic [PERF_CNT_W-1:0]  host_stall_cnt
`endif
);

    arb_state_t      state_q;
    arb_state_t      state_d;
    requester_e      winner;
    logic            win_valid;
    logic            cpu_elig;
    logic            host_elig;
    logic            cpu_win;
    logic            host_win;
    logic            host_starved;
    logic            w_en_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            cpu_rvalid_q;
    logic            host_rvalid_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_dbg_unused;

    // A requester in its own grant cycle is not eligible, so a command
    // presented in the grant cycle is first seen at the following edge
    assign cpu_elig  = bus.cpu_req  && (state_q != ISSUE_CPU);
    assign host_elig = bus.host_req && (state_q != ISSUE_HOST);

    // Winner select and next state: starved host first, then CPU, then host
    always_comb begin
        winner    = REQ_CPU;
        win_valid = 1'b0;
        state_d   = IDLE;
        if (host_elig && host_starved) begin
            winner    = REQ_HOST;
            win_valid = 1'b1;
            state_d   = ISSUE_HOST;
        end else if (cpu_elig) begin
            winner    = REQ_CPU;
            win_valid = 1'b1;
            state_d   = ISSUE_CPU;
        end else if (host_elig) begin
            winner    = REQ_HOST;
            win_valid = 1'b1;
            state_d   = ISSUE_HOST;
        end
    end

    assign cpu_win  = win_valid && (winner == REQ_CPU);
    assign host_win = win_valid && (winner == REQ_HOST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command register: capture the winner; address and data hold when idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_en_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (host_win) begin
            w_en_q  <= bus.host_we;
            addr_q  <= bus.host_addr;
            wdata_q <= bus.host_wdata;
        end else if (cpu_win) begin
            w_en_q  <= bus.cpu_we;
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
        end else begin
            w_en_q  <= 1'b0;
        end
    end

    // Read-valid flops: a load issued this cycle returns data next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q  <= (state_q == ISSUE_CPU)  && !w_en_q;
            host_rvalid_q <= (state_q == ISSUE_HOST) && !w_en_q;
        end
    end

    // Host starvation counter: grows while the host loses, cleared on a host win
    arb_starve_cnt #(
        .WIDTH (WAIT_CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (host_elig && !host_win),
        .clr      (host_win),
        .limit    (WAIT_CNT_W'(STARVE_LIMIT)),
        .count    (wait_cnt_dbg_unused),
        .at_limit (host_starved)
    );

`ifdef RAM_ARB_PERF_EN
    logic cpu_stall_sat_unused;
    logic host_stall_sat_unused;

    // CPU stall counter: cycles the CPU is eligible but loses the decision
    arb_starve_cnt #(
        .WIDTH (PERF_CNT_W)
    ) u_cpu_stall (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (cpu_elig && !cpu_win),
        .clr      (1'b0),
        .limit    ('1),
        .count    (cpu_stall_cnt),
        .at_limit (cpu_stall_sat_unused)
    );

    // Host stall counter: same condition as the starvation counter, never cleared
    arb_starve_cnt #(
        .WIDTH (PERF_CNT_W)
    ) u_host_stall (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (host_elig && !host_win),
        .clr      (1'b0),
        .limit    ('1),
        .count    (host_stall_cnt),
        .at_limit (host_stall_sat_unused)
    );
`endif

    assign bus.cpu_gnt     = (state_q == ISSUE_CPU);
    assign bus.host_gnt    = (state_q == ISSUE_HOST);
    assign bus.cpu_rvalid  = cpu_rvalid_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.ram_w_en2   = w_en_q;
    assign bus.ram_addr2   = addr_q;
    assign bus.ram_in2     = wdata_q;
    assign bus.rdata       = bus.ram_data2;

endmodule

// File: tb/tb_ram2_port_arbiter.sv
// Self-checking bench for ram2_port_arbiter (STARVE_LIMIT = 4).
// A cycle table covers store/load, host write plus CPU read at the top
// address, and alternation. Hand sequences cover the starvation override,
// continuous requests and reset during a load.
// Define RAM_ARB_PERF_EN to also check the stall counters.
module tb_ram2_port_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ram2_port_arbiter_if bus ();

`ifdef RAM_ARB_PERF_EN
    logic [15:0] cpu_stall_cnt;
    logic [15:0] host_stall_cnt;
`endif

    ram2_port_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef RAM_ARB_PERF_EN
        ,
        .cpu_stall_cnt  (cpu_stall_cnt),
        .host_stall_cnt (host_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model, 1-cycle read latency, read-before-write
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (bus.ram_w_en2) mem[bus.ram_addr2] <= bus.ram_in2;
        bus.ram_data2 <= mem[bus.ram_addr2];
    end

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [10:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        host_req;
        logic        host_we;
        logic [10:0] host_addr;
        logic [31:0] host_wdata;
        logic        e_cpu_gnt;
        logic        e_host_gnt;
        logic        e_w_en;
        logic [10:0] e_addr;
        logic [31:0] e_in;
        logic        e_cpu_rvalid;
        logic        e_host_rvalid;
        logic        chk_rdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [15];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.cpu_req    = v.cpu_req;
        bus.cpu_we     = v.cpu_we;
        bus.cpu_addr   = v.cpu_addr;
        bus.cpu_wdata  = v.cpu_wdata;
        bus.host_req   = v.host_req;
        bus.host_we    = v.host_we;
        bus.host_addr  = v.host_addr;
        bus.host_wdata = v.host_wdata;
    endtask

    // Drive plain loads: CPU from 0x040, host from 0x050
    task automatic driveReqs(input logic c, input logic h);
        vec_t v;
        v = '{c, 1'b0, 11'h040, 32'h0, h, 1'b0, 11'h050, 32'h0,
              1'b0, 1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        applyStimulus(v);
    endtask

    task automatic stepGnt(input string tag, input logic exp_c, input logic exp_h);
        @(posedge clk);
        #1;
        checkOutput({tag, "_cpu_gnt"}, {31'b0, bus.cpu_gnt}, {31'b0, exp_c});
        checkOutput({tag, "_host_gnt"}, {31'b0, bus.host_gnt}, {31'b0, exp_h});
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, "_cpu_gnt"},     {31'b0, bus.cpu_gnt},     32'h0);
        checkOutput({tag, "_host_gnt"},    {31'b0, bus.host_gnt},    32'h0);
        checkOutput({tag, "_cpu_rvalid"},  {31'b0, bus.cpu_rvalid},  32'h0);
        checkOutput({tag, "_host_rvalid"}, {31'b0, bus.host_rvalid}, 32'h0);
        checkOutput({tag, "_w_en"},        {31'b0, bus.ram_w_en2},   32'h0);
        checkOutput({tag, "_addr"},        {21'b0, bus.ram_addr2},   32'h0);
        checkOutput({tag, "_in"},          bus.ram_in2,              32'h0);
    endtask

    initial begin
        int seen_c;
        int seen_h;
        int first_h;
`ifdef RAM_ARB_PERF_EN
        int c0;
        int h0;
`endif
        total = 0;
        bad   = 0;

        // cpu_req cpu_we cpu_addr cpu_wdata host_req host_we host_addr host_wdata |
        // e_cpu_gnt e_host_gnt e_w_en e_addr e_in e_cpu_rvalid e_host_rvalid chk_rdata e_rdata
        vecs[0]  = '{1'b1, 1'b1, 11'h010, 32'hDEADBEEF, 1'b0, 1'b0, 11'h000, 32'h0,
                     1'b1, 1'b0, 1'b1, 11'h010, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 11'h010, 32'h0, 1'b0, 1'b0, 11'h000, 32'h0,
                     1'b0, 1'b0, 1'b0, 11'h010, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 11'h010, 32'h0, 1'b0, 1'b0, 11'h000, 32'h0,
                     1'b1, 1'b0, 1'b0, 11'h010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 11'h000, 32'h0, 1'b0, 1'b0, 11'h000, 32'h0,
                     1'b0, 1'b0, 1'b0, 11'h010, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b0, 11'h000, 32'h0, 1'b0, 1'b0, 11'h000, 32'h0,
                     1'b0, 1'b0, 1'b0, 11'h010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 11'h000, 32'h0, 1'b1, 1'b1, 11'h7FF, 32'h12345678,
                     1'b0, 1'b1, 1'b1, 11'h7FF, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 11'h7FF, 32'h0, 1'b0, 1'b0, 11'h000, 32'h0,
                     1'b1, 1'b0, 1'b0, 11'h7FF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 11'h000, 32'h0, 1'b0, 1'b0, 11'h000, 32'h0,
                     1'b0, 1'b0, 1'b0, 11'h7FF, 32'h0, 1'b1, 1'b0, 1'b1, 32'h12345678};
        vecs[8]  = '{1'b0, 1'b0, 11'h000, 32'h0, 1'b0, 1'b0, 11'h000, 32'h0,
                     1'b0, 1'b0, 1'b0, 11'h7FF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 11'h020, 32'h0, 1'b1, 1'b0, 11'h030, 32'h0,
                     1'b1, 1'b0, 1'b0, 11'h020, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 11'h020, 32'h0, 1'b1, 1'b0, 11'h030, 32'h0,
                     1'b0, 1'b1, 1'b0, 11'h030, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 11'h020, 32'h0, 1'b1, 1'b0, 11'h030, 32'h0,
                     1'b1, 1'b0, 1'b0, 11'h020, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 11'h020, 32'h0, 1'b1, 1'b0, 11'h030, 32'h0,
                     1'b0, 1'b1, 1'b0, 11'h030, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 11'h000, 32'h0, 1'b0, 1'b0, 11'h000, 32'h0,
                     1'b0, 1'b0, 1'b0, 11'h030, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 11'h000, 32'h0, 1'b0, 1'b0, 11'h000, 32'h0,
                     1'b0, 1'b0, 1'b0, 11'h030, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};

        // Reset
        rst_n = 1'b0;
        driveReqs(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkAllIdle("reset");
`ifdef RAM_ARB_PERF_EN
        checkOutput("reset_cpu_stall",  {16'b0, cpu_stall_cnt},  32'h0);
        checkOutput("reset_host_stall", {16'b0, host_stall_cnt}, 32'h0);
`endif
        rst_n = 1'b1;

        // Cycle table
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_cpu_gnt", i),     {31'b0, bus.cpu_gnt},     {31'b0, vecs[i].e_cpu_gnt});
            checkOutput($sformatf("v%0d_host_gnt", i),    {31'b0, bus.host_gnt},    {31'b0, vecs[i].e_host_gnt});
            checkOutput($sformatf("v%0d_w_en", i),        {31'b0, bus.ram_w_en2},   {31'b0, vecs[i].e_w_en});
            checkOutput($sformatf("v%0d_addr", i),        {21'b0, bus.ram_addr2},   {21'b0, vecs[i].e_addr});
            checkOutput($sformatf("v%0d_in", i),          bus.ram_in2,              vecs[i].e_in);
            checkOutput($sformatf("v%0d_cpu_rvalid", i),  {31'b0, bus.cpu_rvalid},  {31'b0, vecs[i].e_cpu_rvalid});
            checkOutput($sformatf("v%0d_host_rvalid", i), {31'b0, bus.host_rvalid}, {31'b0, vecs[i].e_host_rvalid});
            if (vecs[i].chk_rdata) begin
                checkOutput($sformatf("v%0d_rdata", i), bus.rdata, vecs[i].e_rdata);
            end
        end

        // Starvation override: host loses, withdraws, and retries until wait_cnt reaches 4
`ifdef RAM_ARB_PERF_EN
        c0 = int'(cpu_stall_cnt);
        h0 = int'(host_stall_cnt);
`endif
        for (int r = 1; r <= 4; r++) begin
            driveReqs(1'b1, 1'b1);
            stepGnt($sformatf("starve_r%0d_a", r), 1'b1, 1'b0);
            driveReqs(1'b0, 1'b0);
            stepGnt($sformatf("starve_r%0d_b", r), 1'b0, 1'b0);
        end
        driveReqs(1'b1, 1'b1);
        stepGnt("starve_override", 1'b0, 1'b1);
        driveReqs(1'b1, 1'b0);
        stepGnt("starve_cpu_next", 1'b1, 1'b0);
        driveReqs(1'b0, 1'b0);
        stepGnt("starve_idle", 1'b0, 1'b0);
        driveReqs(1'b1, 1'b1);
        stepGnt("starve_cleared", 1'b1, 1'b0);
        driveReqs(1'b0, 1'b0);
        stepGnt("starve_end", 1'b0, 1'b0);
`ifdef RAM_ARB_PERF_EN
        checkOutput("starve_host_stall_delta", 32'(int'(host_stall_cnt) - h0), 32'd5);
        checkOutput("starve_cpu_stall_delta",  32'(int'(cpu_stall_cnt) - c0),  32'd1);
        c0 = int'(cpu_stall_cnt);
        h0 = int'(host_stall_cnt);
`endif

        // Both requesting every cycle: strict alternation, CPU first
        seen_c  = 0;
        seen_h  = 0;
        first_h = 99;
        driveReqs(1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.cpu_gnt) seen_c++;
            if (bus.host_gnt) begin
                seen_h++;
                if (first_h == 99) first_h = k;
            end
        end
        driveReqs(1'b0, 1'b0);
        checkOutput("cont_host_first_gnt", 32'(first_h), 32'd2);
        checkOutput("cont_cpu_gnts", 32'(seen_c), 32'd5);
        checkOutput("cont_host_gnts", 32'(seen_h), 32'd5);
        repeat (2) @(posedge clk);
        #1;
`ifdef RAM_ARB_PERF_EN
        checkOutput("cont_host_stall_delta", 32'(int'(host_stall_cnt) - h0), 32'd1);
        checkOutput("cont_cpu_stall_delta",  32'(int'(cpu_stall_cnt) - c0),  32'd0);
`endif

        // Reset asserted during a CPU load issue cycle
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 11'h010;
        @(posedge clk);
        #1;
        checkOutput("rst_pre_cpu_gnt", {31'b0, bus.cpu_gnt}, 32'h1);
        rst_n       = 1'b0;
        bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        checkAllIdle("rst_edge");
`ifdef RAM_ARB_PERF_EN
        checkOutput("rst_cpu_stall",  {16'b0, cpu_stall_cnt},  32'h0);
        checkOutput("rst_host_stall", {16'b0, host_stall_cnt}, 32'h0);
`endif
        @(posedge clk);
        #1;
        checkOutput("rst_hold_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'h0);
        rst_n       = 1'b1;
        bus.cpu_req = 1'b1;
        #1;
        checkOutput("rst_release_cpu_gnt", {31'b0, bus.cpu_gnt}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rst_first_cpu_gnt", {31'b0, bus.cpu_gnt}, 32'h1);
        checkOutput("rst_first_addr", {21'b0, bus.ram_addr2}, 32'h010);
        bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_load_rvalid", {31'b0, bus.cpu_rvalid}, 32'h1);
        checkOutput("rst_load_rdata", bus.rdata, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
